// File: rtl/moving_sum_ring_buffer.sv
// ---------------------------------------------------------------------------
// moving_sum_ring_buffer
//
// Boxcar (moving-sum) filter over the last N = WINDOW+1 accepted samples.
// Each accepted sample is written into a circular buffer. The sample that
// leaves the window, N samples back, is read out of the same buffer and
// subtracted from the running accumulator.
//
// Ports:
//   CLK        clock, all logic on the rising edge
//   RESET      synchronous reset, active-high (wins over everything)
//   CE         1 = accept IN_VALUE and advance, 0 = hold all state
//   WINDOW     window length minus one (N = WINDOW+1, 1..MEM_SIZE)
//   IN_VALUE   signed input sample, consumed on CE=1 cycles
//   OUT_SUM    registered signed sum of the last N accepted samples
//   OUT_VALID  1 = OUT_SUM covers a full window of N samples
//
// Flow control: there is no back-pressure. A sample is taken on every rising
// edge with CE=1, and OUT_SUM/OUT_VALID change only on those edges or on
// RESET.
// ---------------------------------------------------------------------------
module moving_sum_ring_buffer #(
   parameter int DATA_BITS   = 32,
   parameter int WINDOW_BITS = 4
) (
   input  logic                                     CLK,
   input  logic                                     RESET,
   input  logic                                     CE,
   input  logic        [WINDOW_BITS-1:0]            WINDOW,
   input  logic signed [DATA_BITS-1:0]              IN_VALUE,
   output logic signed [DATA_BITS+WINDOW_BITS-1:0]  OUT_SUM,
   output logic                                     OUT_VALID
);

   localparam int MEM_SIZE = 1 << WINDOW_BITS;
   localparam int ACC_BITS = DATA_BITS + WINDOW_BITS;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                       state;
   logic    [DATA_BITS-1:0]      mem [MEM_SIZE];
   logic    [WINDOW_BITS-1:0]    wr_ptr;
   logic    [WINDOW_BITS-1:0]    window_reg;
   logic    [WINDOW_BITS-1:0]    rd_addr;
   logic    [WINDOW_BITS:0]      fill_cnt;
   logic    [WINDOW_BITS:0]      fill_next;
   logic    [WINDOW_BITS:0]      win_len;
   logic signed [ACC_BITS-1:0]   acc;
   logic signed [ACC_BITS-1:0]   in_ext;
   logic signed [ACC_BITS-1:0]   leave_ext;
   logic    [DATA_BITS-1:0]      leaving;
   logic                         window_change;

   // N needs one more bit than WINDOW because N can equal MEM_SIZE.
   assign win_len   = {1'b0, window_reg} + (WINDOW_BITS+1)'(1);
   assign fill_next = fill_cnt + (WINDOW_BITS+1)'(1);

   // Oldest sample of the window. The low bits of N are used so that
   // N = MEM_SIZE wraps to wr_ptr itself, i.e. the slot about to be
   // overwritten. The asynchronous read returns the old contents because
   // the write only lands on the clock edge.
   assign rd_addr   = wr_ptr - win_len[WINDOW_BITS-1:0];
   assign leaving   = mem[rd_addr];

   assign in_ext    = {{WINDOW_BITS{IN_VALUE[DATA_BITS-1]}}, IN_VALUE};
   assign leave_ext = {{WINDOW_BITS{leaving[DATA_BITS-1]}}, leaving};

   assign window_change = (WINDOW != window_reg);

   assign OUT_SUM = acc;

   // Sample storage: no reset, so it maps onto distributed/block RAM.
   always_ff @(posedge CLK) begin
      if (CE) begin
         mem[wr_ptr] <= IN_VALUE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         acc        <= '0;
         OUT_VALID  <= 1'b0;
         wr_ptr     <= '0;
         fill_cnt   <= '0;
         state      <= FILL;
         window_reg <= WINDOW;
      end else if (CE) begin
         wr_ptr <= wr_ptr + WINDOW_BITS'(1);
         if (window_change) begin
            // Restart: the current sample becomes sample #1 of the new window.
            window_reg <= WINDOW;
            acc        <= in_ext;
            fill_cnt   <= (WINDOW_BITS+1)'(1);
            if (WINDOW == '0) begin
               state     <= RUN;
               OUT_VALID <= 1'b1;
            end else begin
               state     <= FILL;
               OUT_VALID <= 1'b0;
            end
         end else begin
            case (state)
               FILL: begin
                  // Buffer contents are stale until N samples have been
                  // written, so nothing is subtracted here.
                  acc      <= acc + in_ext;
                  fill_cnt <= fill_next;
                  if (fill_next == win_len) begin
                     state     <= RUN;
                     OUT_VALID <= 1'b1;
                  end
               end
               RUN: begin
                  acc       <= acc + in_ext - leave_ext;
                  OUT_VALID <= 1'b1;
               end
               default: begin
                  state     <= FILL;
                  OUT_VALID <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_moving_sum_ring_buffer.sv
// ---------------------------------------------------------------------------
// tb_moving_sum_ring_buffer
//
// Directed scenarios plus a randomized run against a reference model that
// keeps the samples accepted since the last restart in a queue and sums
// the newest N of them.
// ---------------------------------------------------------------------------
module tb_moving_sum_ring_buffer;

   localparam int DATA_BITS   = 32;
   localparam int WINDOW_BITS = 4;
   localparam int SUM_BITS    = DATA_BITS + WINDOW_BITS;
   localparam logic signed [SUM_BITS-1:0] MIN_SUM = 36'sh8_0000_0000;

   // ---------------- clock / reset ----------------
   logic                          CLK = 1'b0;
   logic                          RESET = 1'b1;
   logic                          CE = 1'b0;
   logic        [WINDOW_BITS-1:0] WINDOW = '0;
   logic signed [DATA_BITS-1:0]   IN_VALUE = '0;
   logic signed [SUM_BITS-1:0]    OUT_SUM;
   logic                          OUT_VALID;

   always #5 CLK = ~CLK;

   moving_sum_ring_buffer #(
      .DATA_BITS   (DATA_BITS),
      .WINDOW_BITS (WINDOW_BITS)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .CE        (CE),
      .WINDOW    (WINDOW),
      .IN_VALUE  (IN_VALUE),
      .OUT_SUM   (OUT_SUM),
      .OUT_VALID (OUT_VALID)
   );

   // ---------------- reference model / scoreboard ----------------
   logic signed [DATA_BITS-1:0]   exp_q[$];   // samples since last restart
   logic        [WINDOW_BITS-1:0] m_win;
   logic signed [SUM_BITS-1:0]    m_sum;
   logic                          m_valid;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic model_update(input bit rst, input bit ce,
                               input logic [WINDOW_BITS-1:0] win,
                               input logic signed [DATA_BITS-1:0] val);
      longint s;
      int     n;
      if (rst) begin
         exp_q.delete();
         m_win   = win;
         m_sum   = '0;
         m_valid = 1'b0;
      end else if (ce) begin
         if (win != m_win) begin
            exp_q.delete();
            m_win = win;
         end
         exp_q.push_back(val);
         n = int'(m_win) + 1;
         while (exp_q.size() > n) void'(exp_q.pop_front());
         s = 0;
         foreach (exp_q[i]) s += longint'(exp_q[i]);
         m_sum   = s[SUM_BITS-1:0];
         m_valid = (exp_q.size() == n);
      end
   endtask

   // ---------------- driver ----------------
   task automatic cycle(input bit rst, input bit ce,
                        input logic [WINDOW_BITS-1:0] win,
                        input logic signed [DATA_BITS-1:0] val);
      RESET    = rst;
      CE       = ce;
      WINDOW   = win;
      IN_VALUE = val;
      @(posedge CLK);
      model_update(rst, ce, win, val);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      cycle(1'b1, 1'b1, 4'd3, 32'sd77);
      n_checks++;
      if (OUT_SUM !== '0 || OUT_VALID !== 1'b0)
         $display("FAIL reset: OUT_SUM=%0d OUT_VALID=%0b expected 0/0", OUT_SUM, OUT_VALID);
      else n_pass++;
   endtask

   task automatic test_basic();
      int exp_s[6] = '{1, 3, 6, 10, 14, 18};
      bit exp_v[6] = '{0, 0, 0, 1, 1, 1};
      cycle(1'b1, 1'b1, 4'd3, '0);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, 4'd3, DATA_BITS'(i + 1));
         n_checks++;
         if (OUT_SUM !== SUM_BITS'(exp_s[i]) || OUT_VALID !== exp_v[i])
            $display("FAIL basic[%0d]: OUT_SUM=%0d OUT_VALID=%0b expected %0d/%0b",
                     i, OUT_SUM, OUT_VALID, exp_s[i], exp_v[i]);
         else n_pass++;
      end
   endtask

   task automatic test_full_window();
      cycle(1'b1, 1'b1, 4'd15, '0);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b1, 4'd15, 32'sd100);
         n_checks++;
         if (OUT_SUM !== SUM_BITS'(100 * (i < 16 ? i + 1 : 16)) || OUT_VALID !== (i >= 15))
            $display("FAIL full_window_100[%0d]: OUT_SUM=%0d OUT_VALID=%0b expected %0d/%0b",
                     i, OUT_SUM, OUT_VALID, 100 * (i < 16 ? i + 1 : 16), (i >= 15));
         else n_pass++;
      end
      cycle(1'b1, 1'b1, 4'd15, '0);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b1, 4'd15, 32'sh8000_0000);
         n_checks++;
         if (OUT_SUM !== m_sum || OUT_VALID !== m_valid)
            $display("FAIL full_window_min[%0d]: OUT_SUM=%0d OUT_VALID=%0b expected %0d/%0b",
                     i, OUT_SUM, OUT_VALID, m_sum, m_valid);
         else n_pass++;
      end
      n_checks++;
      if (OUT_SUM !== MIN_SUM || OUT_VALID !== 1'b1)
         $display("FAIL full_window_min_final: OUT_SUM=%0d expected %0d", OUT_SUM, MIN_SUM);
      else n_pass++;
   endtask

   task automatic test_window0();
      int exp_s[3] = '{7, -3, 9};
      cycle(1'b1, 1'b1, 4'd0, '0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 4'd0, DATA_BITS'(exp_s[i]));
         n_checks++;
         if (OUT_SUM !== SUM_BITS'(exp_s[i]) || OUT_VALID !== 1'b1)
            $display("FAIL window0[%0d]: OUT_SUM=%0d OUT_VALID=%0b expected %0d/1",
                     i, OUT_SUM, OUT_VALID, exp_s[i]);
         else n_pass++;
      end
   endtask

   task automatic test_ce_gaps();
      int exp_s[4] = '{1, 3, 6, 10};
      bit exp_v[4] = '{0, 0, 0, 1};
      cycle(1'b1, 1'b1, 4'd3, '0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 4'd3, DATA_BITS'(i + 1));
         n_checks++;
         if (OUT_SUM !== SUM_BITS'(exp_s[i]) || OUT_VALID !== exp_v[i])
            $display("FAIL ce_gaps_sample[%0d]: OUT_SUM=%0d OUT_VALID=%0b expected %0d/%0b",
                     i, OUT_SUM, OUT_VALID, exp_s[i], exp_v[i]);
         else n_pass++;
         if (i < 3) begin
            for (int g = 0; g < 2; g++) begin
               // WINDOW wiggles during the gap after sample 2 but is restored
               // before the next accepted sample, so no restart happens.
               cycle(1'b0, 1'b0, (i == 1) ? 4'd7 : 4'd3, $urandom);
               n_checks++;
               if (OUT_SUM !== SUM_BITS'(exp_s[i]) || OUT_VALID !== exp_v[i])
                  $display("FAIL ce_gaps_hold[%0d.%0d]: OUT_SUM=%0d OUT_VALID=%0b expected %0d/%0b",
                           i, g, OUT_SUM, OUT_VALID, exp_s[i], exp_v[i]);
               else n_pass++;
            end
         end
      end
      // A WINDOW change that persists through a gap takes effect only on
      // the next accepted sample.
      cycle(1'b0, 1'b0, 4'd1, 32'sd999);
      n_checks++;
      if (OUT_SUM !== 36'sd10 || OUT_VALID !== 1'b1)
         $display("FAIL ce_gaps_pending_change: OUT_SUM=%0d OUT_VALID=%0b expected 10/1",
                  OUT_SUM, OUT_VALID);
      else n_pass++;
      cycle(1'b0, 1'b1, 4'd1, 32'sd50);
      n_checks++;
      if (OUT_SUM !== 36'sd50 || OUT_VALID !== 1'b0)
         $display("FAIL ce_gaps_restart: OUT_SUM=%0d OUT_VALID=%0b expected 50/0",
                  OUT_SUM, OUT_VALID);
      else n_pass++;
   endtask

   task automatic test_window_change();
      int exp_s[3] = '{10, 30, 50};
      bit exp_v[3] = '{0, 1, 1};
      cycle(1'b1, 1'b1, 4'd3, '0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 4'd3, DATA_BITS'(i + 1));
      n_checks++;
      if (OUT_SUM !== 36'sd18 || OUT_VALID !== 1'b1)
         $display("FAIL window_change_pre: OUT_SUM=%0d OUT_VALID=%0b expected 18/1",
                  OUT_SUM, OUT_VALID);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 4'd1, DATA_BITS'(10 * (i + 1)));
         n_checks++;
         if (OUT_SUM !== SUM_BITS'(exp_s[i]) || OUT_VALID !== exp_v[i])
            $display("FAIL window_change[%0d]: OUT_SUM=%0d OUT_VALID=%0b expected %0d/%0b",
                     i, OUT_SUM, OUT_VALID, exp_s[i], exp_v[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_run();
      cycle(1'b1, 1'b1, 4'd3, '0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'd3, 32'sd5);
      n_checks++;
      if (OUT_SUM !== 36'sd20 || OUT_VALID !== 1'b1)
         $display("FAIL reset_mid_run_pre: OUT_SUM=%0d OUT_VALID=%0b expected 20/1",
                  OUT_SUM, OUT_VALID);
      else n_pass++;
      cycle(1'b1, 1'b1, 4'd3, 32'sd5);
      n_checks++;
      if (OUT_SUM !== '0 || OUT_VALID !== 1'b0)
         $display("FAIL reset_mid_run_rst: OUT_SUM=%0d OUT_VALID=%0b expected 0/0",
                  OUT_SUM, OUT_VALID);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 4'd3, 32'sd1);
         n_checks++;
         if (OUT_SUM !== SUM_BITS'(i + 1) || OUT_VALID !== (i == 3))
            $display("FAIL reset_mid_run[%0d]: OUT_SUM=%0d OUT_VALID=%0b expected %0d/%0b",
                     i, OUT_SUM, OUT_VALID, i + 1, (i == 3));
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [WINDOW_BITS-1:0] win;
      bit rst, ce;
      win = WINDOW_BITS'($urandom_range(0, 15));
      cycle(1'b1, 1'b1, win, '0);
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         ce  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 39) == 0) win = WINDOW_BITS'($urandom_range(0, 15));
         cycle(rst, ce, win, $urandom);
         n_checks++;
         if (OUT_SUM !== m_sum || OUT_VALID !== m_valid)
            $display("FAIL random[%0d]: OUT_SUM=%0d OUT_VALID=%0b expected %0d/%0b",
                     i, OUT_SUM, OUT_VALID, m_sum, m_valid);
         else n_pass++;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      m_win   = '0;
      m_sum   = '0;
      m_valid = 1'b0;
      test_reset();
      test_basic();
      test_full_window();
      test_window0();
      test_ce_gaps();
      test_window_change();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/moving_sum_ring_buffer.md
Name: moving_sum_ring_buffer

Overview:
Boxcar (moving-sum) filter over a variable-length window of the last N = WINDOW+1 input samples. It is built on a circular buffer: the writer stores each sample, and the reader retrieves the sample leaving the window, N samples back. It sits after sensor period/frequency measurement stages to smooth readings. Downstream logic divides or normalizes the sum.

Parameters:
DATA_BITS, 32, signed input sample width
WINDOW_BITS, 4, ring buffer holds MEM_SIZE = 1<<WINDOW_BITS samples; window length N = 1..MEM_SIZE

Ports:
CLK  input  1  clock; all logic on rising edge
RESET  input  1  synchronous reset, active-high
CE  input  1  clock enable; 1 = accept IN_VALUE and advance, 0 = hold all state
WINDOW  input  WINDOW_BITS  window length minus one (N = WINDOW+1)
IN_VALUE  input  DATA_BITS signed  input sample, consumed on CE=1 cycles
OUT_SUM  output  DATA_BITS+WINDOW_BITS signed  registered sum of last N accepted samples
OUT_VALID  output  1  1 = OUT_SUM covers a full window of N samples

Behaviour:
- Reset (RESET=1 at a clock edge, regardless of CE): acc=0, OUT_SUM=0, OUT_VALID=0, wr_ptr=0, fill_cnt=0, state=FILL, window_reg=WINDOW. Buffer RAM is not cleared; FILL masking makes stale contents irrelevant.
- Reset during operation has the same effect as the initial reset. The first CE cycle after reset is sample #1.
- CE=0: every register holds, including OUT_SUM, OUT_VALID, pointers and window_reg. A WINDOW change is not seen until the next CE=1 cycle.
- On each CE=1 cycle:
  - Write IN_VALUE to mem[wr_ptr]; wr_ptr increments mod MEM_SIZE.
  - Read leaving = mem[(wr_ptr - N) mod MEM_SIZE] using old contents (read-before-write). When N=MEM_SIZE this reads mem[wr_ptr] before it is overwritten.
- States:
  - FILL: acc <= acc + IN_VALUE, with leaving treated as 0; fill_cnt increments. When fill_cnt reaches N (the Nth sample is accepted this cycle), go to RUN and set OUT_VALID=1 in the same edge.
  - RUN: acc <= acc + IN_VALUE - leaving; OUT_VALID stays 1.
- Latency: OUT_SUM updates on the edge that accepts a sample and includes that sample (1 register stage). OUT_SUM mirrors acc.
- Window change: if CE=1 and WINDOW != window_reg, the block restarts.
  - window_reg <= WINDOW; state=FILL; OUT_VALID=0.
  - acc <= IN_VALUE and fill_cnt=1 (the current sample is sample #1).
  - wr_ptr continues and is written normally.
  - With the new N=1, the block goes to RUN and OUT_VALID=1 immediately on that edge.
- Simultaneous RESET and window change: RESET wins.
- Width: acc is DATA_BITS+WINDOW_BITS signed. MEM_SIZE * (extreme DATA_BITS value) fits, so wrap never occurs. All adds and subtracts are sign-extended.
- N=1 (WINDOW=0): OUT_SUM = last accepted sample; OUT_VALID=1 after the first accepted sample.
- Implementation: the RAM must infer as distributed/block RAM, not a shift register. The leaving-sample read may be registered internally, but externally visible latency must remain exactly as specified.

Test Plan:
1. Reset, WINDOW=3, CE=1, feed 1,2,3,4,5,6 -> OUT_SUM 1,3,6,10,14,18; OUT_VALID 0,0,0,1,1,1.
2. WINDOW=15 (N=16), constant 100 for 20 samples -> OUT_SUM ramps 100..1600, OUT_VALID rises on sample 16, then holds 1600. Repeat with constant -(2^31): sum -2^35 exact, no wrap.
3. WINDOW=0, feed 7,-3,9 -> OUT_SUM 7,-3,9; OUT_VALID=1 from the first sample.
4. WINDOW=3, feed 1..4 with CE=0 gaps of 2 cycles between samples, and change WINDOW during a gap -> OUT_SUM/OUT_VALID frozen during gaps. Final results match scenario 1. Restart occurs only on the next CE=1 cycle.
5. Window change mid-stream: WINDOW=3 in RUN after 1..6 (sum 18), set WINDOW=1, feed 10,20,30 -> OUT_SUM 10,30,50; OUT_VALID 0,1,1.
6. Reset mid-RUN: WINDOW=3, feed 5,5,5,5,5 (sum 20), assert RESET one cycle with CE=1 -> OUT_SUM=0, OUT_VALID=0. Then feed 1,1,1,1 -> 1,2,3,4, valid on the 4th sample, with no stale 5s included.
